// File: rtl/modulo_pkg.sv
// rtl/modulo_pkg.sv - shared encodings and defaults for the attack-entry datapath
package modulo_pkg;

    localparam int          COORD_W     = 3;
    localparam int          N_COL_DEF   = 5;
    localparam int          N_LIN_DEF   = 7;
    localparam logic [1:0]  ATTACK_MODE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEL_COL = 2'd1,
        ST_SEL_LIN = 2'd2,
        ST_FIRE    = 2'd3
    } at_state_e;

    // Coordinate step with wrap at the last valid index
    function automatic logic [COORD_W-1:0] wrap_inc(input logic [COORD_W-1:0] v, input int n);
        return (v == COORD_W'(n - 1)) ? '0 : v + COORD_W'(1);
    endfunction

endpackage

// File: rtl/modulo_entrada_ataque_if.sv
// rtl/modulo_entrada_ataque_if.sv - button/mode inputs and attack coordinate outputs
interface modulo_entrada_ataque_if;
    import modulo_pkg::*;

    logic [1:0]         hh1;
    logic               button_count;
    logic               button_confirmation;
    logic [COORD_W-1:0] coord_coluna;
    logic [COORD_W-1:0] coord_linha;
    logic [1:0]         at_state;
    logic               at_fire;
    logic               at_dup;

    modport master (
        output hh1, button_count, button_confirmation,
        input  coord_coluna, coord_linha, at_state, at_fire, at_dup
    );

    modport slave (
        input  hh1, button_count, button_confirmation,
        output coord_coluna, coord_linha, at_state, at_fire, at_dup
    );

endinterface

// File: rtl/modulo_debounce.sv
// rtl/modulo_debounce.sv - 2-FF synchroniser plus stability counter; one-cycle pulse on accepted press
module modulo_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic button,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             settled;

    assign settled = (cnt == CNT_W'(DEB_CYCLES - 1));

    // cnt counts consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (settled) begin
                cnt    <= '0;
                stable <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = (sync2 != stable) && settled && !sync2;

endmodule

// File: rtl/modulo_entrada_ataque.sv
// rtl/modulo_entrada_ataque.sv - attack coordinate entry FSM; MODULO_AT_DUP_FILTER_EN adds repeated-shot filter
module modulo_entrada_ataque
    import modulo_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int N_COL      = N_COL_DEF,
    parameter int N_LIN      = N_LIN_DEF
) (
    input  logic                    clk,
    input  logic                    clr_n,
    modulo_entrada_ataque_if.slave  bus
);

    logic               count_press;
    logic               confirm_press;
    at_state_e          state, state_nx;
    logic [COORD_W-1:0] col, col_nx;
    logic [COORD_W-1:0] lin, lin_nx;
    logic               fire, fire_nx;
    logic               dup, dup_nx;
    logic               shot_seen;
    logic               attack;

    modulo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_count (
        .clk    (clk),
        .clr_n  (clr_n),
        .button (bus.button_count),
        .press  (count_press)
    );

    modulo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_confirm (
        .clk    (clk),
        .clr_n  (clr_n),
        .button (bus.button_confirmation),
        .press  (confirm_press)
    );

    assign attack = (bus.hh1 == ATTACK_MODE);

`ifdef MODULO_AT_DUP_FILTER_EN
    localparam int MAP_W = N_COL * N_LIN;
    localparam int IDX_W = $clog2(MAP_W);

    logic [MAP_W-1:0] map, map_nx;
    logic [IDX_W-1:0] idx;

    assign idx       = IDX_W'(int'(lin) * N_COL + int'(col));
    assign shot_seen = map[idx];

    // Map is only written on the SEL_LIN confirm that leads into FIRE
    always_comb begin
        map_nx = map;
        if (!attack) begin
            map_nx = '0;
        end else if (state == ST_SEL_LIN && confirm_press && !shot_seen) begin
            map_nx[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) map <= '0;
        else        map <= map_nx;
    end
`else
    assign shot_seen = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        col_nx   = col;
        lin_nx   = lin;
        fire_nx  = 1'b0;
        dup_nx   = 1'b0;
        if (!attack) begin
            state_nx = ST_IDLE;
            col_nx   = '0;
            lin_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_SEL_COL;
                    col_nx   = '0;
                    lin_nx   = '0;
                end
                ST_SEL_COL: begin
                    if (confirm_press)    state_nx = ST_SEL_LIN;
                    else if (count_press) col_nx   = wrap_inc(col, N_COL);
                end
                ST_SEL_LIN: begin
                    // Fire/dup registered here so they line up with the FIRE cycle
                    if (confirm_press) begin
                        state_nx = ST_FIRE;
                        fire_nx  = !shot_seen;
                        dup_nx   = shot_seen;
                    end else if (count_press) begin
                        lin_nx = wrap_inc(lin, N_LIN);
                    end
                end
                ST_FIRE:  state_nx = ST_SEL_COL;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            col   <= '0;
            lin   <= '0;
            fire  <= 1'b0;
            dup   <= 1'b0;
        end else begin
            state <= state_nx;
            col   <= col_nx;
            lin   <= lin_nx;
            fire  <= fire_nx;
            dup   <= dup_nx;
        end
    end

    assign bus.coord_coluna = col;
    assign bus.coord_linha  = lin;
    assign bus.at_state     = state;
    assign bus.at_fire      = fire;
    assign bus.at_dup       = dup;

endmodule

// File: tb/tb_modulo_entrada_ataque.sv
// tb/tb_modulo_entrada_ataque.sv - randomized self-checking bench against a behavioural attack-entry model
module tb_modulo_entrada_ataque;
    import modulo_pkg::*;

    localparam int DEB = 4;
    localparam int NC  = 5;
    localparam int NL  = 7;
`ifdef MODULO_AT_DUP_FILTER_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    modulo_entrada_ataque_if bus ();

    modulo_entrada_ataque #(.DEB_CYCLES(DEB), .N_COL(NC), .N_LIN(NL)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: game position as plain integers and a set of fired cells
    int m_state, m_col, m_lin;
    bit m_fired [NC*NL];
    int obs_fire, obs_dup, fire_col, fire_lin;

    task automatic model_clear();
        m_state = 1;
        m_col   = 0;
        m_lin   = 0;
        foreach (m_fired[i]) m_fired[i] = 1'b0;
    endtask

    task automatic model_press(input bit cnt, input bit conf, output int e_fire, output int e_dup);
        e_fire = 0;
        e_dup  = 0;
        if (conf) begin
            if (m_state == 1) begin
                m_state = 2;
            end else if (m_state == 2) begin
                if (DUP_EN && m_fired[m_lin*NC + m_col]) begin
                    e_dup = 1;
                end else begin
                    e_fire = 1;
                    m_fired[m_lin*NC + m_col] = 1'b1;
                end
                m_state = 1;
            end
        end else if (cnt) begin
            if (m_state == 1)      m_col = (m_col + 1) % NC;
            else if (m_state == 2) m_lin = (m_lin + 1) % NL;
        end
    endtask

    // Holds the selected buttons low 10 cycles, then released 10 cycles; records fire/dup activity
    task automatic press(input bit cnt, input bit conf);
        obs_fire = 0;
        obs_dup  = 0;
        fire_col = -1;
        fire_lin = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                if (cnt)  bus.button_count        = 1'b0;
                if (conf) bus.button_confirmation = 1'b0;
            end
            if (i == 10) begin
                bus.button_count        = 1'b1;
                bus.button_confirmation = 1'b1;
            end
            @(negedge clk);
            if (bus.at_fire === 1'b1) begin
                obs_fire++;
                fire_col = int'(bus.coord_coluna);
                fire_lin = int'(bus.coord_linha);
            end
            if (bus.at_dup === 1'b1) obs_dup++;
        end
    endtask

    task automatic do_op(input bit cnt, input bit conf, output int e_fire, output int e_dup);
        press(cnt, conf);
        model_press(cnt, conf, e_fire, e_dup);
    endtask

    task automatic toggle_mode();
        int t;
        @(posedge clk);
        #1;
        t = $urandom_range(0, 2);
        bus.hh1 = (t == 2) ? 2'b11 : 2'(t);
        repeat (3) @(posedge clk);
        #1;
        bus.hh1 = ATTACK_MODE;
        repeat (2) @(posedge clk);
        model_clear();
    endtask

    task automatic test_reset();
        bus.hh1 = 2'b10;
        bus.button_count = 1'b1;
        bus.button_confirmation = 1'b1;
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.at_state, bus.coord_coluna, bus.coord_linha, bus.at_fire, bus.at_dup} !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {bus.at_state, bus.coord_coluna, bus.coord_linha, bus.at_fire, bus.at_dup});
        end
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            clr_n = 1'b1;
            @(negedge clk);
            tests_run++;
            if (bus.at_state !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_release_idle: got state %0d, expected 0", bus.at_state);
            end
            @(negedge clk);
            tests_run++;
            if (bus.at_state !== 2'd1) begin
                tests_failed++;
                $display("FAIL reset_release_selcol: got state %0d, expected 1", bus.at_state);
            end
            repeat (10) @(posedge clk);
            if (r == 0) begin
                press(1'b1, 1'b0);
                tests_run++;
                if (bus.coord_coluna !== 3'd1) begin
                    tests_failed++;
                    $display("FAIL reset_precount: got col %0d, expected 1", bus.coord_coluna);
                end
                @(posedge clk);
                #2;
                clr_n = 1'b0;
                #1;
                tests_run++;
                if ({bus.at_state, bus.coord_coluna, bus.coord_linha, bus.at_fire, bus.at_dup} !== 10'b0) begin
                    tests_failed++;
                    $display("FAIL reset_async: got %b, expected all zero",
                             {bus.at_state, bus.coord_coluna, bus.coord_linha, bus.at_fire, bus.at_dup});
                end
            end
        end
        model_clear();
    endtask

    task automatic test_debounce();
        @(posedge clk);
        #1;
        bus.button_count = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.button_count = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.coord_coluna !== 3'd0) begin
            tests_failed++;
            $display("FAIL debounce_glitch: got col %0d, expected 0", bus.coord_coluna);
        end
        @(posedge clk);
        #1;
        bus.button_count = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) begin
                tests_run++;
                if (bus.coord_coluna !== 3'd0) begin
                    tests_failed++;
                    $display("FAIL debounce_early: got col %0d at cycle 5, expected 0", bus.coord_coluna);
                end
            end
            if (k == 6) begin
                tests_run++;
                if (bus.coord_coluna !== 3'd1) begin
                    tests_failed++;
                    $display("FAIL debounce_latency: got col %0d at cycle 6, expected 1", bus.coord_coluna);
                end
            end
        end
        repeat (4) @(posedge clk);
        #1;
        bus.button_count = 1'b1;
        repeat (10) @(posedge clk);
        m_col = 1;
    endtask

    task automatic test_wrap();
        int ef, ed;
        for (int i = 0; i < NC; i++) do_op(1'b1, 1'b0, ef, ed);
        @(negedge clk);
        tests_run++;
        if ({bus.at_state, bus.coord_coluna, bus.coord_linha} !== {2'(m_state), 3'(m_col), 3'(m_lin)}) begin
            tests_failed++;
            $display("FAIL wrap_col: got st=%0d col=%0d lin=%0d, expected st=%0d col=%0d lin=%0d",
                     bus.at_state, bus.coord_coluna, bus.coord_linha, m_state, m_col, m_lin);
        end
        do_op(1'b0, 1'b1, ef, ed);
        for (int i = 0; i < NL; i++) do_op(1'b1, 1'b0, ef, ed);
        @(negedge clk);
        tests_run++;
        if ({bus.at_state, bus.coord_coluna, bus.coord_linha} !== {2'd2, 3'(m_col), 3'd0}) begin
            tests_failed++;
            $display("FAIL wrap_lin: got st=%0d col=%0d lin=%0d, expected st=2 col=%0d lin=0",
                     bus.at_state, bus.coord_coluna, bus.coord_linha, m_col);
        end
    endtask

    task automatic select_and_fire(input int c, input int l, output int ef, output int ed);
        for (int i = 0; i < c; i++) do_op(1'b1, 1'b0, ef, ed);
        do_op(1'b0, 1'b1, ef, ed);
        for (int i = 0; i < l; i++) do_op(1'b1, 1'b0, ef, ed);
        do_op(1'b0, 1'b1, ef, ed);
    endtask

    task automatic test_shot();
        int ef, ed;
        toggle_mode();
        @(negedge clk);
        tests_run++;
        if ({bus.at_state, bus.coord_coluna, bus.coord_linha} !== 8'b01_000_000) begin
            tests_failed++;
            $display("FAIL shot_start: got st=%0d col=%0d lin=%0d, expected st=1 col=0 lin=0",
                     bus.at_state, bus.coord_coluna, bus.coord_linha);
        end
        select_and_fire(3, 5, ef, ed);
        tests_run++;
        if (obs_fire != 1 || obs_dup != 0 || fire_col != 3 || fire_lin != 5) begin
            tests_failed++;
            $display("FAIL shot_fire: got fire=%0d dup=%0d at (%0d,%0d), expected fire=1 dup=0 at (3,5)",
                     obs_fire, obs_dup, fire_col, fire_lin);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.at_state, bus.coord_coluna, bus.coord_linha} !== 8'b01_011_101) begin
            tests_failed++;
            $display("FAIL shot_after: got st=%0d col=%0d lin=%0d, expected st=1 col=3 lin=5",
                     bus.at_state, bus.coord_coluna, bus.coord_linha);
        end
    endtask

    task automatic test_abort();
        int ef, ed;
        do_op(1'b0, 1'b1, ef, ed);
        obs_fire = 0;
        @(posedge clk);
        #1;
        bus.button_confirmation = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.hh1 = 2'b01;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.at_fire === 1'b1) obs_fire++;
            if (i == 4) bus.button_confirmation = 1'b1;
        end
        tests_run++;
        if ({bus.at_state, bus.coord_coluna, bus.coord_linha} !== 8'b0 || obs_fire != 0) begin
            tests_failed++;
            $display("FAIL abort: got st=%0d col=%0d lin=%0d fire=%0d, expected st=0 col=0 lin=0 fire=0",
                     bus.at_state, bus.coord_coluna, bus.coord_linha, obs_fire);
        end
        @(posedge clk);
        #1;
        bus.hh1 = ATTACK_MODE;
        repeat (2) @(posedge clk);
        model_clear();
    endtask

`ifdef MODULO_AT_DUP_FILTER_EN
    task automatic test_dup();
        int ef, ed;
        select_and_fire(3, 5, ef, ed);
        tests_run++;
        if (obs_fire != 1 || obs_dup != 0) begin
            tests_failed++;
            $display("FAIL dup_first: got fire=%0d dup=%0d, expected fire=1 dup=0", obs_fire, obs_dup);
        end
        select_and_fire(0, 0, ef, ed);
        tests_run++;
        if (obs_fire != 0 || obs_dup != 1) begin
            tests_failed++;
            $display("FAIL dup_second: got fire=%0d dup=%0d, expected fire=0 dup=1", obs_fire, obs_dup);
        end
        toggle_mode();
        select_and_fire(3, 5, ef, ed);
        tests_run++;
        if (obs_fire != 1 || obs_dup != 0 || fire_col != 3 || fire_lin != 5) begin
            tests_failed++;
            $display("FAIL dup_after_clear: got fire=%0d dup=%0d at (%0d,%0d), expected fire=1 dup=0 at (3,5)",
                     obs_fire, obs_dup, fire_col, fire_lin);
        end
    endtask
`endif

    task automatic test_random();
        int ef, ed, r, pcol, plin;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 9) begin
                toggle_mode();
            end else begin
                pcol = m_col;
                plin = m_lin;
                do_op(r < 5, r >= 5, ef, ed);
                tests_run++;
                if (obs_fire != ef || obs_dup != ed || (ef == 1 && (fire_col != pcol || fire_lin != plin))) begin
                    tests_failed++;
                    $display("FAIL random_shot[%0d]: got fire=%0d dup=%0d at (%0d,%0d), expected fire=%0d dup=%0d at (%0d,%0d)",
                             n, obs_fire, obs_dup, fire_col, fire_lin, ef, ed, pcol, plin);
                end
            end
            @(negedge clk);
            tests_run++;
            if ({bus.at_state, bus.coord_coluna, bus.coord_linha} !== {2'(m_state), 3'(m_col), 3'(m_lin)}) begin
                tests_failed++;
                $display("FAIL random_state[%0d]: got st=%0d col=%0d lin=%0d, expected st=%0d col=%0d lin=%0d",
                         n, bus.at_state, bus.coord_coluna, bus.coord_linha, m_state, m_col, m_lin);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_shot();
        test_abort();
`ifdef MODULO_AT_DUP_FILTER_EN
        test_dup();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
